bus_write_arbiter: RTL and testbench
====================================

# bus_write_arbiter

Round-robin write arbiter and sequencer for the shared 8-bit `my_if` valid/ready write bus. It accepts single-beat write requests (address + data) from up to `NUM_REQ` requesters. It grants one requester at a time and drives the bus as the bus master side (data/valid out, ready in). It reports per-transfer completion with a success/timeout status, and sits between the requesting agents and the bus endpoint.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8)
- `AW`, 8: address width
- `DW`, 8: data width
- `TIMEOUT`, 15: consecutive stalled bus cycles before abort (1..255)

- `clk` input 1: clock, rising edge
- `rst_n` input 1: reset, asynchronous, active-low
- `req_valid` input NUM_REQ: per-requester write request, held until acked
- `req_addr` input NUM_REQ*AW: packed addresses, requester i at [i*AW +: AW]
- `req_wdata` input NUM_REQ*DW: packed write data, same packing
- `req_ack` output NUM_REQ: one-hot, 1-cycle pulse, request captured
- `bus_addr` output AW: address of current transfer
- `bus_data` output DW: `my_if.data`
- `bus_valid` output 1: `my_if.valid`
- `bus_ready` input 1: `my_if.ready`
- `grant_id` output clog2(NUM_REQ): index of last granted requester
- `done` output 1: 1-cycle pulse, transfer finished
- `write_status` output 1: qualified by `done`; 1 = accepted, 0 = timed out; holds value until next `done`

## Operation
- FSM with two states: IDLE and BUSY.
- IDLE: if any `req_valid` is set, pick the winner round-robin, scanning from `grant_id+1` upward with wrap. Capture that requester's addr/wdata into `bus_addr`/`bus_data`, set `grant_id`, then go to BUSY.
- BUSY: `bus_valid`=1, and `bus_addr`/`bus_data` are held stable. The wait counter increments each cycle in which `bus_ready`=0.
  - `bus_ready`=1 sampled: go to IDLE with `bus_valid`=0, `done`=1, `write_status`=1.
  - Wait counter reaches `TIMEOUT` with `bus_ready` still 0: go to IDLE with `bus_valid`=0, `done`=1, `write_status`=0.
  - Counter clears on entry to BUSY.
- `req_ack[grant_id]` pulses in the first BUSY cycle. A requester still asserting `req_valid` after the ack is treated as a new request.
- `bus_ready` is ignored in IDLE.
- Round-robin pointer is `grant_id`. Its reset value is NUM_REQ-1, so requester 0 has highest priority after reset.
- A requester that drops `req_valid` before it is acked is simply not granted. There is no error.
- Unused `req_valid` bits (index ≥ NUM_REQ) do not exist; width is exact.

## Timing
- Reset values: `bus_valid`=0, `bus_addr`=0, `bus_data`=0, `req_ack`=0, `done`=0, `write_status`=0, `grant_id`=NUM_REQ-1, FSM=IDLE, counter=0.
- Request-to-bus latency: `req_valid` sampled at edge N in IDLE gives `bus_valid`=1 and `req_ack` pulse in cycle N+1.
- Completion: `bus_ready`=1 sampled at edge M gives `bus_valid`=0 and `done`=1 in cycle M+1.
- A fully ready bus gives 1 beat per 2 cycles. The `done` cycle is an IDLE cycle in which the next arbitration happens, so the next `bus_valid` follows one bubble cycle later.
- Timeout: `done` with `write_status`=0 occurs TIMEOUT+1 cycles after `bus_valid` rises when `bus_ready` stays 0.
- Simultaneous `bus_ready`=1 and counter reaching TIMEOUT resolves as success.
- Asynchronous reset mid-BUSY drops the transfer immediately: `bus_valid`=0 and no `done`. The requester has already been acked and must retry at its own discretion.

## Test plan
- Single request: requester 1, addr 0x10, data 0xA5, `bus_ready` tied 1.
  - `bus_valid` high exactly 1 cycle with 0x10/0xA5.
  - `req_ack`=4'b0010.
  - `done`=1 and `write_status`=1 next cycle.
- All 4 requesters held valid from reset, `bus_ready`=1 → grants in order 0,1,2,3,0, with one bubble between beats.
- Stall: `bus_ready` held low 3 cycles then high → data stable for 4 `bus_valid` cycles, then `write_status`=1.
- Timeout: TIMEOUT=15, `bus_ready` never high → `done` with `write_status`=0 16 cycles after `bus_valid` rises. The next request is then served normally.
- Fairness: requester 2 continuously valid, requester 0 asserts mid-transfer → requester 0 is granted next, before requester 2 is re-granted.
- Reset asserted in the second BUSY cycle → all outputs at reset values asynchronously, no `done`, and `grant_id`=3 after release.

Source files
------------

// File: rtl/bus_write_arbiter.sv
// bus_write_arbiter: round-robin write arbiter that serialises single-beat
// address/data writes from NUM_REQ requesters onto the shared my_if
// valid/ready bus. It reports each finished transfer as accepted or timed out.
module bus_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*AW-1:0]      req_addr,
    input  logic [NUM_REQ*DW-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [AW-1:0]              bus_addr,
    output logic [DW-1:0]              bus_data,
    output logic                       bus_valid,
    input  logic                       bus_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       done,
    output logic                       write_status
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [GW-1:0]     r_grantId;
    logic [AW-1:0]     r_busAddr;
    logic [DW-1:0]     r_busData;
    logic [NUM_REQ-1:0] r_ack;
    logic [CW-1:0]     r_waitCnt;
    logic              r_done;
    logic              r_status;

    logic              w_found;
    logic [GW-1:0]     w_winner;
    logic [AW-1:0]     w_winAddr;
    logic [DW-1:0]     w_winData;
    logic              w_capture;
    logic              w_finish;
    logic              w_success;

    // Round-robin pick: first scan requesters above the last grant, then wrap to the rest
    always_comb begin
        w_found   = 1'b0;
        w_winner  = r_grantId;
        w_winAddr = '0;
        w_winData = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && req_valid[j] && (j > int'(r_grantId))) begin
                w_found   = 1'b1;
                w_winner  = GW'(j);
                w_winAddr = req_addr[j*AW +: AW];
                w_winData = req_wdata[j*DW +: DW];
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && req_valid[j] && (j <= int'(r_grantId))) begin
                w_found   = 1'b1;
                w_winner  = GW'(j);
                w_winAddr = req_addr[j*AW +: AW];
                w_winData = req_wdata[j*DW +: DW];
            end
        end
    end

    // FSM state register; async reset drops any transfer in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: grant when idle, finish on ready (wins over timeout) or on timeout
    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        w_finish    = 1'b0;
        w_success   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_nextState = S_BUSY;
                    w_capture   = 1'b1;
                end
            end
            S_BUSY: begin
                if (bus_ready) begin
                    w_nextState = S_IDLE;
                    w_finish    = 1'b1;
                    w_success   = 1'b1;
                end else if (r_waitCnt == CW'(TIMEOUT)) begin
                    w_nextState = S_IDLE;
                    w_finish    = 1'b1;
                end
            end
        endcase
    end

    // Datapath: latch the winner's beat, pulse ack/done, count stalled bus cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busAddr <= '0;
            r_busData <= '0;
            r_grantId <= GW'(NUM_REQ - 1);
            r_ack     <= '0;
            r_waitCnt <= '0;
            r_done    <= 1'b0;
            r_status  <= 1'b0;
        end else begin
            r_ack  <= '0;
            r_done <= 1'b0;
            if (w_capture) begin
                r_busAddr <= w_winAddr;
                r_busData <= w_winData;
                r_grantId <= w_winner;
                r_ack     <= NUM_REQ'(1) << w_winner;
                r_waitCnt <= '0;
            end else if ((r_state == S_BUSY) && !bus_ready) begin
                r_waitCnt <= r_waitCnt + CW'(1);
            end
            if (w_finish) begin
                r_done   <= 1'b1;
                r_status <= w_success;
            end
        end
    end

    assign bus_valid    = (r_state == S_BUSY);
    assign bus_addr     = r_busAddr;
    assign bus_data     = r_busData;
    assign grant_id     = r_grantId;
    assign req_ack      = r_ack;
    assign done         = r_done;
    assign write_status = r_status;

endmodule

// File: tb/tb_bus_write_arbiter.sv
// tb_bus_write_arbiter: directed checks of bus_write_arbiter with
// hand-computed expectations (reset, single write, round-robin, stall,
// timeout, fairness, async reset mid-transfer).
module tb_bus_write_arbiter;

    localparam int NUM_REQ = 4;
    localparam int AW      = 8;
    localparam int DW      = 8;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*AW-1:0]   req_addr;
    logic [NUM_REQ*DW-1:0]   req_wdata;
    logic [NUM_REQ-1:0]      req_ack;
    logic [AW-1:0]           bus_addr;
    logic [DW-1:0]           bus_data;
    logic                    bus_valid;
    logic                    bus_ready;
    logic [1:0]              grant_id;
    logic                    done;
    logic                    write_status;

    int testsRun = 0;
    int testsFailed = 0;

    bus_write_arbiter #(
        .NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .bus_addr(bus_addr), .bus_data(bus_data),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .grant_id(grant_id),
        .done(done), .write_status(write_status)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Load one requester's address/data slot
    task automatic applyStimulus(input int idx, input logic [7:0] addr, input logic [7:0] data);
        req_addr[idx*AW +: AW]  = addr;
        req_wdata[idx*DW +: DW] = data;
    endtask

    // Pulse reset across one rising edge and release just after it
    task automatic doReset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Check the beat of a just-granted transfer
    task automatic checkGrant(input string tag, input int id, input logic [7:0] addr, input logic [7:0] data);
        checkOutput({tag, "_valid"}, 32'(bus_valid), 1);
        checkOutput({tag, "_grant"}, 32'(grant_id), 32'(id));
        checkOutput({tag, "_ack"}, 32'(req_ack), 32'(1) << id);
        checkOutput({tag, "_addr"}, 32'(bus_addr), 32'(addr));
        checkOutput({tag, "_data"}, 32'(bus_data), 32'(data));
    endtask

    // Check the done cycle after a transfer
    task automatic checkDone(input string tag, input logic status);
        checkOutput({tag, "_done"}, 32'(done), 1);
        checkOutput({tag, "_status"}, 32'(write_status), 32'(status));
        checkOutput({tag, "_validLow"}, 32'(bus_valid), 0);
    endtask

    initial begin
        int order[5];
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_wdata = '0;
        bus_ready = 1'b0;
        #12;

        // Reset values
        checkOutput("rst_valid", 32'(bus_valid), 0);
        checkOutput("rst_addr", 32'(bus_addr), 0);
        checkOutput("rst_data", 32'(bus_data), 0);
        checkOutput("rst_ack", 32'(req_ack), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_status", 32'(write_status), 0);
        checkOutput("rst_grant", 32'(grant_id), 3);
        rst_n = 1'b1;
        tick();

        // Single request from requester 1, bus always ready
        applyStimulus(1, 8'h10, 8'hA5);
        req_valid = 4'b0010;
        bus_ready = 1'b1;
        tick();
        checkGrant("single", 1, 8'h10, 8'hA5);
        checkOutput("single_noDone", 32'(done), 0);
        req_valid = 4'b0000;
        tick();
        checkDone("single", 1'b1);
        checkOutput("single_ackLow", 32'(req_ack), 0);
        tick();
        checkOutput("single_oneBeat", 32'(bus_valid), 0);
        checkOutput("single_donePulse", 32'(done), 0);
        checkOutput("single_statusHold", 32'(write_status), 1);

        // All four valid from reset: 0,1,2,3,0 with one bubble between beats
        for (int i = 0; i < 4; i++) applyStimulus(i, 8'(8'h20 + i), 8'(8'h30 + i));
        req_valid = 4'b1111;
        doReset();
        order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            tick();
            checkGrant("rr", order[k], 8'(8'h20 + order[k]), 8'(8'h30 + order[k]));
            tick();
            checkDone("rr", 1'b1);
        end
        req_valid = 4'b0000;

        // Stall: ready low for three bus cycles, then high
        doReset();
        applyStimulus(2, 8'h44, 8'h5C);
        req_valid = 4'b0100;
        bus_ready = 1'b0;
        tick();
        req_valid = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            checkOutput("stall_valid", 32'(bus_valid), 1);
            checkOutput("stall_data", 32'(bus_data), 32'h5C);
            checkOutput("stall_addr", 32'(bus_addr), 32'h44);
            checkOutput("stall_noDone", 32'(done), 0);
            bus_ready = (k == 4);
            tick();
        end
        checkDone("stall", 1'b1);

        // Timeout: ready never rises, done 16 cycles after valid rises
        applyStimulus(3, 8'h66, 8'h77);
        req_valid = 4'b1000;
        bus_ready = 1'b0;
        tick();
        checkGrant("tmo", 3, 8'h66, 8'h77);
        req_valid = 4'b0000;
        for (int k = 1; k <= 16; k++) begin
            checkOutput("tmo_validHeld", 32'(bus_valid), 1);
            checkOutput("tmo_noDone", 32'(done), 0);
            tick();
        end
        checkDone("tmo", 1'b0);

        // Next request after a timeout is served normally
        applyStimulus(0, 8'h01, 8'h02);
        req_valid = 4'b0001;
        bus_ready = 1'b1;
        tick();
        checkGrant("post", 0, 8'h01, 8'h02);
        req_valid = 4'b0000;
        tick();
        checkDone("post", 1'b1);

        // Fairness: requester 2 held, requester 0 joins mid-transfer and wins next
        applyStimulus(2, 8'h50, 8'h51);
        applyStimulus(0, 8'h60, 8'h61);
        req_valid = 4'b0100;
        bus_ready = 1'b0;
        tick();
        checkGrant("fair1", 2, 8'h50, 8'h51);
        req_valid = 4'b0101;
        bus_ready = 1'b1;
        tick();
        checkDone("fair1", 1'b1);
        tick();
        checkGrant("fair2", 0, 8'h60, 8'h61);
        req_valid = 4'b0100;
        tick();
        checkDone("fair2", 1'b1);
        tick();
        checkGrant("fair3", 2, 8'h50, 8'h51);
        req_valid = 4'b0000;
        tick();
        checkDone("fair3", 1'b1);

        // Async reset in the second BUSY cycle drops the transfer
        applyStimulus(1, 8'h90, 8'h91);
        req_valid = 4'b0010;
        bus_ready = 1'b0;
        tick();
        checkGrant("arst", 1, 8'h90, 8'h91);
        req_valid = 4'b0000;
        tick();
        checkOutput("arst_busy2", 32'(bus_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(bus_valid), 0);
        checkOutput("arst_addr", 32'(bus_addr), 0);
        checkOutput("arst_data", 32'(bus_data), 0);
        checkOutput("arst_ack", 32'(req_ack), 0);
        checkOutput("arst_done", 32'(done), 0);
        checkOutput("arst_status", 32'(write_status), 0);
        checkOutput("arst_grant", 32'(grant_id), 3);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("arst_noDone", 32'(done), 0);
            checkOutput("arst_idle", 32'(bus_valid), 0);
            checkOutput("arst_grantAfter", 32'(grant_id), 3);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
